// File: rtl/line_prefetch_ring_if.sv
// SDRAM line-burst port between the prefetch ring (master) and the SDRAM arbiter (slave).
interface line_prefetch_ring_if #(
  parameter int ADDR_W = 24,
  parameter int PIX_W  = 16
) ();
  logic              sdram_line_req;
  logic              sdram_line_grant;
  logic [ADDR_W-1:0] sdram_line_addr;
  logic [PIX_W-1:0]  sdram_line_data;
  logic              sdram_line_valid;
  logic              sdram_line_done;

  modport master (
    output sdram_line_req, sdram_line_addr,
    input  sdram_line_grant, sdram_line_data, sdram_line_valid, sdram_line_done
  );

  modport slave (
    input  sdram_line_req, sdram_line_addr,
    output sdram_line_grant, sdram_line_data, sdram_line_valid, sdram_line_done
  );
endinterface

// File: rtl/line_prefetch_ring.sv
// Ring of NUM_SLOTS scanline buffers prefetched from SDRAM in bursts, serving scanout pixel reads.
// Optional macro UNDERRUN_PATTERN_EN: checkerboard instead of black for reads of a line not yet loaded.
module line_prefetch_ring #(
  parameter int LINE_PIXELS = 1024,
  parameter int PIX_W       = 16,
  parameter int NUM_SLOTS   = 2,
  parameter int BURST_LEN   = 128,
  parameter int V_LINES     = 768,
  parameter int ADDR_W      = 24,
  parameter int Y_W         = 12
) (
  input  logic                           clk_sys,
  input  logic                           rst_n,
  input  logic                           enable_i,
  input  logic                           line_start_i,
  input  logic [Y_W-1:0]                 line_y_i,
  input  logic [ADDR_W-1:0]              fb_base_addr_i,
  input  logic                           rd_en_i,
  input  logic [$clog2(LINE_PIXELS)-1:0] rd_x_i,
  output logic [PIX_W-1:0]               rd_data_o,
  output logic                           line_ready_o,
  output logic [15:0]                    underrun_cnt_o,
  output logic [2:0]                     debug_fill_state_o,
  line_prefetch_ring_if.master           sdram
);

  localparam int XW   = $clog2(LINE_PIXELS);
  localparam int SW   = $clog2(NUM_SLOTS);
  localparam int NBLK = LINE_PIXELS / BURST_LEN;
  localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int BW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int YP   = Y_W + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_BURST  = 3'd2,
    S_COMMIT = 3'd3
  } state_e;

  state_e            state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [Y_W-1:0]    fill_y_q;
  logic [SW-1:0]     fill_slot_q;
  logic [KW-1:0]     blk_q;
  logic [BW-1:0]     beat_q;
  logic              beat_full_q;
  logic              abort_q;
  logic              complete_q;

  logic [Y_W-1:0]    cur_y_q, cur_y_d;
  logic              win_act_q, win_act_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [Y_W-1:0]    tag_q [NUM_SLOTS];
  logic [Y_W-1:0]    tag_d [NUM_SLOTS];
  logic [15:0]       underrun_cnt_q, underrun_cnt_d;
  logic              line_ready_q, line_ready_d;
  logic [PIX_W-1:0]  rd_data_q;

  logic [PIX_W-1:0]  mem_q [NUM_SLOTS*LINE_PIXELS];

  logic              tgt_vld_s;
  logic [Y_W-1:0]    tgt_y_s;
  logic              abort_set_s;
  logic              abort_now_s;
  logic              commit_s;
  logic              new_held_s;
  logic              cur_held_s;
  logic              wr_en_s;
  logic [XW-1:0]     wr_off_s;
  logic [ADDR_W-1:0] req_addr_s;
  logic [PIX_W-1:0]  underrun_pix_s;

  // Distance from base to tag, modulo V_LINES, lies inside the prefetch window.
  function automatic logic in_win(input logic [Y_W-1:0] tag, input logic [Y_W-1:0] base);
    logic [YP-1:0] d;
    if (tag >= base) d = {1'b0, tag} - {1'b0, base};
    else             d = {1'b0, tag} + YP'(V_LINES) - {1'b0, base};
    return d < YP'(NUM_SLOTS);
  endfunction

  function automatic logic [Y_W-1:0] win_line(input logic [Y_W-1:0] base, input int k);
    logic [YP-1:0] s;
    s = {1'b0, base} + YP'(k);
    return (s >= YP'(V_LINES)) ? Y_W'(s - YP'(V_LINES)) : s[Y_W-1:0];
  endfunction

  assign new_held_s  = valid_q[line_y_i[SW-1:0]] && (tag_q[line_y_i[SW-1:0]] == line_y_i);
  assign cur_held_s  = valid_q[cur_y_q[SW-1:0]] && (tag_q[cur_y_q[SW-1:0]] == cur_y_q);
  assign abort_set_s = line_start_i && (state_q != S_IDLE) && !in_win(fill_y_q, line_y_i);
  assign abort_now_s = abort_q || abort_set_s;
  assign commit_s    = (state_q == S_COMMIT) && complete_q && !abort_q;
  assign wr_en_s     = (state_q == S_BURST) && sdram.sdram_line_valid && !beat_full_q;

  // Fill target: the nearest window line whose slot does not yet hold it.
  always_comb begin : tgt_sel
    logic [Y_W-1:0] ly;
    tgt_vld_s = 1'b0;
    tgt_y_s   = '0;
    ly        = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      ly = win_line(cur_y_q, k);
      if (!(valid_q[ly[SW-1:0]] && (tag_q[ly[SW-1:0]] == ly))) begin
        tgt_vld_s = 1'b1;
        tgt_y_s   = ly;
      end else begin
        tgt_vld_s = tgt_vld_s;
      end
    end
    if (!(win_act_q && enable_i)) tgt_vld_s = 1'b0;
    else                          tgt_vld_s = tgt_vld_s;
  end

  // Burst address and in-line write offset.
  always_comb begin
    req_addr_s = ADDR_W'(fb_base_addr_i + ADDR_W'(fill_y_q) * ADDR_W'(LINE_PIXELS)
                         + ADDR_W'(blk_q) * ADDR_W'(BURST_LEN));
    wr_off_s   = XW'(XW'(blk_q) * XW'(BURST_LEN)) + XW'(beat_q);
  end

  // Slot bookkeeping; invalidation is applied after the commit so it wins on the same slot.
  always_comb begin
    valid_d        = valid_q;
    tag_d          = tag_q;
    cur_y_d        = cur_y_q;
    win_act_d      = win_act_q;
    underrun_cnt_d = underrun_cnt_q;
    if (commit_s) begin
      valid_d[fill_slot_q] = 1'b1;
      tag_d[fill_slot_q]   = fill_y_q;
    end else begin
      valid_d = valid_d;
    end
    if (line_start_i) begin
      cur_y_d   = line_y_i;
      win_act_d = 1'b1;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (valid_d[s] && !in_win(tag_d[s], line_y_i)) valid_d[s] = 1'b0;
        else                                          valid_d[s] = valid_d[s];
      end
      if (!new_held_s && (underrun_cnt_q != 16'hFFFF)) underrun_cnt_d = underrun_cnt_q + 16'd1;
      else                                             underrun_cnt_d = underrun_cnt_q;
    end else begin
      cur_y_d = cur_y_q;
    end
    line_ready_d = valid_d[cur_y_d[SW-1:0]] && (tag_d[cur_y_d[SW-1:0]] == cur_y_d);
  end

`ifdef UNDERRUN_PATTERN_EN
  assign underrun_pix_s = (rd_x_i[5] ^ cur_y_q[5]) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
`else
  assign underrun_pix_s = {PIX_W{1'b0}};
`endif

  // Fill FSM with its registered SDRAM request outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      fill_y_q    <= '0;
      fill_slot_q <= '0;
      blk_q       <= '0;
      beat_q      <= '0;
      beat_full_q <= 1'b0;
      abort_q     <= 1'b0;
      complete_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tgt_vld_s && !line_start_i) begin
            fill_y_q    <= tgt_y_s;
            fill_slot_q <= tgt_y_s[SW-1:0];
            blk_q       <= '0;
            abort_q     <= 1'b0;
            complete_q  <= 1'b0;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          abort_q <= abort_now_s;
          if (!req_q) begin
            req_q  <= 1'b1;
            addr_q <= req_addr_s;
          end else if (sdram.sdram_line_grant) begin
            beat_q      <= '0;
            beat_full_q <= 1'b0;
            state_q     <= S_BURST;
          end
        end
        S_BURST: begin
          abort_q <= abort_now_s;
          if (wr_en_s) begin
            if (beat_q == BW'(BURST_LEN - 1)) beat_full_q <= 1'b1;
            else                              beat_q      <= beat_q + BW'(1);
          end
          if (sdram.sdram_line_done) begin
            req_q <= 1'b0;
            if ((blk_q < KW'(NBLK - 1)) && enable_i && !abort_now_s) begin
              blk_q   <= blk_q + KW'(1);
              state_q <= S_REQ;
            end else begin
              complete_q <= (blk_q == KW'(NBLK - 1));
              state_q    <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          state_q <= S_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Window, slot tags, underrun counter and line_ready.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cur_y_q        <= '0;
      win_act_q      <= 1'b0;
      valid_q        <= '0;
      underrun_cnt_q <= 16'd0;
      line_ready_q   <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) tag_q[s] <= '0;
    end else begin
      cur_y_q        <= cur_y_d;
      win_act_q      <= win_act_d;
      valid_q        <= valid_d;
      underrun_cnt_q <= underrun_cnt_d;
      line_ready_q   <= line_ready_d;
      for (int s = 0; s < NUM_SLOTS; s++) tag_q[s] <= tag_d[s];
    end
  end

  // Pixel read port; holds its value when not strobed.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= cur_held_s ? mem_q[{cur_y_q[SW-1:0], rd_x_i}] : underrun_pix_s;
    end
  end

  // Line storage; contents are not reset, validity lives in valid_q.
  always_ff @(posedge clk_sys) begin
    if (wr_en_s) mem_q[{fill_slot_q, wr_off_s}] <= sdram.sdram_line_data;
  end

  assign sdram.sdram_line_req  = req_q;
  assign sdram.sdram_line_addr = addr_q;
  assign rd_data_o             = rd_data_q;
  assign line_ready_o          = line_ready_q;
  assign underrun_cnt_o        = underrun_cnt_q;
  assign debug_fill_state_o    = state_q;

endmodule

// File: tb/tb_line_prefetch_ring.sv
// Directed bench for line_prefetch_ring with a simple SDRAM burst responder (data = address low bits).
module tb_line_prefetch_ring;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        enable_i;
  logic        line_start_i;
  logic [11:0] line_y_i;
  logic [23:0] fb_base_addr_i;
  logic        rd_en_i;
  logic [9:0]  rd_x_i;
  logic [15:0] rd_data_o;
  logic        line_ready_o;
  logic [15:0] underrun_cnt_o;
  logic [2:0]  debug_fill_state_o;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] req_log [$];
  int          beats_cfg = 128;

  always #5 clk_sys = ~clk_sys;

  line_prefetch_ring_if #(.ADDR_W(24), .PIX_W(16)) sdram_if ();

  line_prefetch_ring dut (
    .clk_sys            (clk_sys),
    .rst_n              (rst_n),
    .enable_i           (enable_i),
    .line_start_i       (line_start_i),
    .line_y_i           (line_y_i),
    .fb_base_addr_i     (fb_base_addr_i),
    .rd_en_i            (rd_en_i),
    .rd_x_i             (rd_x_i),
    .rd_data_o          (rd_data_o),
    .line_ready_o       (line_ready_o),
    .underrun_cnt_o     (underrun_cnt_o),
    .debug_fill_state_o (debug_fill_state_o),
    .sdram              (sdram_if)
  );

  // SDRAM responder: grant a pending request, then stream beats with done on the last one.
  initial begin
    logic [23:0] a;
    int          nb;
    sdram_if.sdram_line_grant = 1'b0;
    sdram_if.sdram_line_valid = 1'b0;
    sdram_if.sdram_line_done  = 1'b0;
    sdram_if.sdram_line_data  = 16'h0000;
    forever begin
      @(negedge clk_sys);
      if (sdram_if.sdram_line_req === 1'b1) begin
        a  = sdram_if.sdram_line_addr;
        nb = beats_cfg;
        req_log.push_back(a);
        sdram_if.sdram_line_grant = 1'b1;
        @(negedge clk_sys);
        sdram_if.sdram_line_grant = 1'b0;
        for (int i = 0; i < nb; i++) begin
          sdram_if.sdram_line_valid = 1'b1;
          sdram_if.sdram_line_data  = a[15:0] + 16'(i);
          sdram_if.sdram_line_done  = (i == nb - 1);
          @(negedge clk_sys);
        end
        sdram_if.sdram_line_valid = 1'b0;
        sdram_if.sdram_line_done  = 1'b0;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_log(input int n);
    int t = 0;
    while (req_log.size() < n && t < 6000) begin
      @(negedge clk_sys);
      t++;
    end
    check($sformatf("log_reached_%0d", n), 32'(req_log.size() >= n), 32'd1);
  endtask

  task automatic pulse_line(input logic [11:0] y);
    line_y_i     = y;
    line_start_i = 1'b1;
    @(negedge clk_sys);
    line_start_i = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] x, input logic [15:0] exp, input string tag);
    rd_x_i  = x;
    rd_en_i = 1'b1;
    @(negedge clk_sys);
    rd_en_i = 1'b0;
    check(tag, 32'(rd_data_o), 32'(exp));
  endtask

  initial begin
    rst_n          = 1'b0;
    enable_i       = 1'b0;
    line_start_i   = 1'b0;
    line_y_i       = 12'd0;
    fb_base_addr_i = 24'h000000;
    rd_en_i        = 1'b0;
    rd_x_i         = 10'd0;
    idle(3);
    check("rst_req",      32'(sdram_if.sdram_line_req),  32'd0);
    check("rst_addr",     32'(sdram_if.sdram_line_addr), 32'd0);
    check("rst_rd_data",  32'(rd_data_o),                32'd0);
    check("rst_ready",    32'(line_ready_o),             32'd0);
    check("rst_underrun", 32'(underrun_cnt_o),           32'd0);
    check("rst_state",    32'(debug_fill_state_o),       32'd0);
    rst_n = 1'b1;
    idle(2);
    fb_base_addr_i = 24'h010000;
    enable_i       = 1'b1;

    // Line 5 cold start: lines 5 and 6 prefetched in 16 bursts.
    pulse_line(12'd5);
    wait_log(16);
    idle(200);
    for (int i = 0; i < 16; i++)
      check($sformatf("t1_addr%0d", i), 32'(req_log[i]), 32'h011400 + 32'(i) * 32'd128);
    check("t1_log_size", 32'(req_log.size()), 32'd16);
    check("t1_ready",    32'(line_ready_o),   32'd1);
    check("t1_underrun", 32'(underrun_cnt_o), 32'd1);
    do_read(10'd3, 16'h1403, "t1_rd_x3");

    // Advance to line 6: no underrun, line 7 refills the freed slot.
    pulse_line(12'd6);
    check("t2_underrun", 32'(underrun_cnt_o), 32'd1);
    check("t2_ready",    32'(line_ready_o),   32'd1);
    wait_log(24);
    idle(200);
    check("t2_addr16", 32'(req_log[16]), 32'h011C00);
    check("t2_addr23", 32'(req_log[23]), 32'h011F80);
    do_read(10'd7, 16'h1807, "t2_rd_x7");

    // Frame wrap: window {767, 0}.
    pulse_line(12'd767);
    check("t3_underrun", 32'(underrun_cnt_o), 32'd2);
    check("t3_ready0",   32'(line_ready_o),   32'd0);
    wait_log(40);
    idle(200);
    check("t3_addr24", 32'(req_log[24]), 32'h0CFC00);
    check("t3_addr31", 32'(req_log[31]), 32'h0CFF80);
    check("t3_addr32", 32'(req_log[32]), 32'h010000);
    check("t3_addr39", 32'(req_log[39]), 32'h010380);
    check("t3_ready1", 32'(line_ready_o), 32'd1);
    do_read(10'd5, 16'hFC05, "t3_rd_x5");

    // Jump away while line 11 is mid-burst: the fill is discarded.
    pulse_line(12'd10);
    check("t4_underrun10", 32'(underrun_cnt_o), 32'd3);
    wait_log(50);
    check("t4_addr40", 32'(req_log[40]), 32'h012800);
    check("t4_addr48", 32'(req_log[48]), 32'h012C00);
    check("t4_addr49", 32'(req_log[49]), 32'h012C80);
    pulse_line(12'd40);
    check("t4_underrun40", 32'(underrun_cnt_o), 32'd4);
    check("t4_ready_a",    32'(line_ready_o),   32'd0);
    wait_log(51);
    check("t4_addr50",  32'(req_log[50]), 32'h01A000);
    check("t4_ready_b", 32'(line_ready_o), 32'd0);
    wait_log(66);
    idle(200);
    check("t4_addr58",    32'(req_log[58]),     32'h01A400);
    check("t4_log_size",  32'(req_log.size()),  32'd66);
    check("t4_ready_c",   32'(line_ready_o),    32'd1);

    // Short (100) and long (130) bursts on line 42; slot 0 previously held line 40.
    beats_cfg = 100;
    pulse_line(12'd42);
    check("t5_underrun", 32'(underrun_cnt_o), 32'd5);
    wait_log(67);
    beats_cfg = 130;
    wait_log(68);
    beats_cfg = 128;
    wait_log(82);
    idle(200);
    check("t5_addr66", 32'(req_log[66]), 32'h01A800);
    check("t5_addr73", 32'(req_log[73]), 32'h01AB80);
    check("t5_addr74", 32'(req_log[74]), 32'h01AC00);
    check("t5_ready",  32'(line_ready_o), 32'd1);
    do_read(10'd99,  16'hA863, "t5_rd_x99");
    do_read(10'd100, 16'hA064, "t5_rd_stale100");
    do_read(10'd127, 16'hA07F, "t5_rd_stale127");
    do_read(10'd128, 16'hA880, "t5_rd_x128");
    do_read(10'd255, 16'hA8FF, "t5_rd_x255");
    do_read(10'd256, 16'hA900, "t5_rd_x256");

    // Fills disabled: reads of an unloaded line give the underrun pixel.
    enable_i = 1'b0;
    pulse_line(12'd0);
    check("t6_underrun", 32'(underrun_cnt_o), 32'd6);
    check("t6_ready",    32'(line_ready_o),   32'd0);
    do_read(10'd3, 16'h0000, "t6_rd_x3");
`ifdef UNDERRUN_PATTERN_EN
    do_read(10'd32, 16'hFFFF, "t6_rd_x32");
`else
    do_read(10'd32, 16'h0000, "t6_rd_x32");
`endif
    idle(10);
    check("t6_req",      32'(sdram_if.sdram_line_req), 32'd0);
    check("t6_state",    32'(debug_fill_state_o),      32'd0);
    check("t6_log_size", 32'(req_log.size()),          32'd82);

    // Reset in the middle of a burst.
    enable_i = 1'b1;
    wait_log(83);
    check("t7_addr82", 32'(req_log[82]), 32'h010000);
    idle(20);
    rst_n = 1'b0;
    #2;
    check("t7_req",      32'(sdram_if.sdram_line_req),  32'd0);
    check("t7_addr",     32'(sdram_if.sdram_line_addr), 32'd0);
    check("t7_underrun", 32'(underrun_cnt_o),           32'd0);
    check("t7_ready",    32'(line_ready_o),             32'd0);
    check("t7_rd_data",  32'(rd_data_o),                32'd0);
    check("t7_state",    32'(debug_fill_state_o),       32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(300);
    check("t7_req_after", 32'(sdram_if.sdram_line_req), 32'd0);
    check("t7_log_size",  32'(req_log.size()),          32'd83);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
